// File: rtl/fsub_serial.sv
// Digit-serial unsigned subtractor d = a - b: WIDTH/DIGIT RUN cycles, done pulses N+1 cycles after start; start is ignored while busy.
// Optional FSUB_SAT_EN: clamp d to zero when the subtraction borrows (bo still reports the borrow).
module fsub_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_nxt;
   logic [WIDTH-1:0] slice_ext;
   logic [DIGIT:0]   slice;
   logic             borrow;
   logic [CW-1:0]    cnt;
   logic             load;
   logic             step;
   logic             finish;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // DONE accepts a new start exactly like IDLE, so held start gives one result per N+1 cycles
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == LAST) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Slice top bit is the borrow-out: a negative (D+1)-bit result always has its MSB set
   always_comb begin
      slice     = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
      slice_ext = WIDTH'(slice[DIGIT-1:0]);
      res_nxt   = (res_sh >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         d      <= '0;
         bo     <= 1'b0;
      end else begin
         if (load) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
         end else if (step) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            res_sh <= res_nxt;
            borrow <= slice[DIGIT];
            cnt    <= cnt + CW'(1);
         end
         if (finish) begin
`ifdef FSUB_SAT_EN
            d <= slice[DIGIT] ? '0 : res_nxt;
`else
            d <= res_nxt;
`endif
            bo <= slice[DIGIT];
         end
      end
   end

endmodule

// File: tb/tb_fsub_serial.sv
// Randomized and directed checks of fsub_serial at DIGIT=1 (unit 0) and DIGIT=4 (unit 1) against an arithmetic model.
module tb_fsub_serial;

   logic             clk = 1'b0;
   logic [1:0]       rst_v;
   logic [1:0]       start_v;
   logic [1:0][15:0] a_v;
   logic [1:0][15:0] b_v;
   logic [1:0]       busy_v;
   logic [1:0]       done_v;
   logic [1:0][15:0] d_v;
   logic [1:0]       bo_v;

   int n_tests = 0;
   int n_fail  = 0;
   int nn [2]  = '{16, 4};

   always #5 clk = ~clk;

   fsub_serial #(.WIDTH(16), .DIGIT(1)) u_dut0 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .d(d_v[0]), .bo(bo_v[0])
   );

   fsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut1 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .d(d_v[1]), .bo(bo_v[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                 output logic [15:0] dd, output logic bb);
      bb = (x < y);
      dd = x - y;
`ifdef FSUB_SAT_EN
      if (bb) dd = 16'h0000;
`endif
   endfunction

   task automatic run_op(input int u, input logic [15:0] ai, input logic [15:0] bi, input bit glitch);
      int          cyc;
      logic [15:0] ed;
      logic        eb;
      model(ai, bi, ed, eb);
      @(negedge clk);
      start_v[u] = 1'b1;
      a_v[u]     = ai;
      b_v[u]     = bi;
      @(negedge clk);
      start_v[u] = 1'b0;
      a_v[u]     = 16'($urandom);
      b_v[u]     = 16'($urandom);
      cyc = 0;
      while (busy_v[u] && cyc < 100) begin
         cyc++;
         if (glitch && cyc == 5) begin
            start_v[u] = 1'b1;
            a_v[u]     = 16'h0001;
            b_v[u]     = 16'h0002;
         end else begin
            start_v[u] = 1'b0;
         end
         @(negedge clk);
         a_v[u] = 16'($urandom);
         b_v[u] = 16'($urandom);
      end
      start_v[u] = 1'b0;
      check($sformatf("busy_cycles_u%0d", u), cyc, nn[u]);
      check($sformatf("done_u%0d", u), done_v[u], 1);
      check($sformatf("no_overlap_u%0d", u), busy_v[u] & done_v[u], 0);
      check($sformatf("d_u%0d_%h_%h", u, ai, bi), d_v[u], ed);
      check($sformatf("bo_u%0d_%h_%h", u, ai, bi), bo_v[u], eb);
      @(negedge clk);
      check($sformatf("done_single_u%0d", u), done_v[u], 0);
      check($sformatf("d_held_u%0d", u), d_v[u], ed);
   endtask

   task automatic reset_test(input int u);
      bit seen;
      @(negedge clk);
      start_v[u] = 1'b1;
      a_v[u]     = 16'h4321;
      b_v[u]     = 16'h0021;
      @(negedge clk);
      start_v[u] = 1'b0;
      repeat (7) @(negedge clk);
      rst_v[u] = 1'b1;
      @(negedge clk);
      check("rst_busy", busy_v[u], 0);
      check("rst_done", done_v[u], 0);
      check("rst_d", d_v[u], 0);
      check("rst_bo", bo_v[u], 0);
      rst_v[u] = 1'b0;
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done_v[u]) seen = 1'b1;
      end
      check("no_done_after_rst", seen, 0);
   endtask

   task automatic held_start(input int u);
      int          cnt;
      logic [15:0] ed;
      logic        eb;
      model(16'h0005, 16'h0003, ed, eb);
      @(negedge clk);
      start_v[u] = 1'b1;
      a_v[u]     = 16'h0005;
      b_v[u]     = 16'h0003;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!done_v[u] && cnt < 100);
      check($sformatf("held_first_u%0d", u), cnt, nn[u] + 1);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("held_d_u%0d_%0d", u, k), d_v[u], ed);
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (!done_v[u] && cnt < 100);
         check($sformatf("held_interval_u%0d_%0d", u, k), cnt, nn[u] + 1);
      end
      start_v[u] = 1'b0;
      repeat (nn[u] + 4) @(negedge clk);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      rst_v   = 2'b11;
      start_v = 2'b00;
      a_v     = '0;
      b_v     = '0;
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check($sformatf("reset_busy_u%0d", u), busy_v[u], 0);
         check($sformatf("reset_done_u%0d", u), done_v[u], 0);
         check($sformatf("reset_d_u%0d", u), d_v[u], 0);
         check($sformatf("reset_bo_u%0d", u), bo_v[u], 0);
      end
      rst_v = 2'b00;

      run_op(0, 16'h1234, 16'h0034, 1'b0);
      check("d_1234_const", d_v[0], 16'h1200);
      run_op(0, 16'h0000, 16'h0001, 1'b0);
      run_op(0, 16'hFFFF, 16'hFFFF, 1'b0);
      run_op(0, 16'h8000, 16'h7FFF, 1'b0);
      run_op(0, 16'h00F0, 16'h000F, 1'b1);
      check("d_glitch_const", d_v[0], 16'h00E1);
      reset_test(0);
      held_start(0);
      held_start(1);
      run_op(1, 16'h0000, 16'h0001, 1'b0);
      run_op(1, 16'h8000, 16'h7FFF, 1'b0);

      for (int i = 0; i < 30; i++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = 16'h0000;
            default: rb = 16'($urandom);
         endcase
         run_op(i % 2, ra, rb, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fsub_serial.md
# fsub_serial

Sequential 16-bit unsigned subtractor, the inverse of the combinational ripple-carry adder in the FMAC datapath. Computes d = a − b over WIDTH/DIGIT clock cycles, DIGIT bits per cycle, with a registered borrow chain. Used where the exponent/mantissa compare-and-align path can tolerate multi-cycle latency in exchange for one small DIGIT-bit subtract slice. Start/busy/done handshake toward the FMAC control FSM.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits subtracted per cycle; legal values are 1, 2, 4, 8, 16.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only while busy = 0.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  operation in progress.
- done  output  1  single-cycle pulse: d/bo valid.
- d  output  WIDTH  difference, held until next accepted start.
- bo  output  1  borrow out (1 when a < b unsigned), held with d.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: busy = 0. start = 1 → capture a, b into shift registers, clear borrow flop and slice counter, → RUN.
- RUN: busy = 1. Each cycle, the DIGIT LSBs of both shift registers plus the borrow flop go through a DIGIT-bit subtract slice. The slice result shifts into the MSB end of the result register. Operands shift right by DIGIT. The slice borrow-out loads the borrow flop. The counter increments. After N = WIDTH/DIGIT slices → DONE.
- DONE: done = 1 for one cycle, busy = 0. d = result register, bo = final borrow. Next state is IDLE. If start = 1 in DONE, it is accepted exactly as in IDLE (capture, → RUN).
- start while busy = 1 is ignored; operands are not re-captured.
- a and b may change freely after acceptance without affecting the result.
- Arithmetic is modulo 2^WIDTH. bo is the true unsigned borrow. Identical to a + ~b + 1 with bo = ~carry.
- d and bo update only on the transition into DONE. They are held otherwise, including across IDLE and a following RUN.

## Timing
- Reset values: busy = 0, done = 0, d = 0, bo = 0. FSM goes to IDLE, counter and borrow flop clear.
- rst has priority over every other input. rst asserted mid-RUN aborts the operation: d and bo are set to 0, no done pulse is issued.
- Accepted start at edge k: busy = 1 from k+1 through k+N. done = 1 and new d/bo are visible from edge k+N+1 for one cycle.
- Latency from start to done is N+1 cycles (17 at the defaults). Back-to-back throughput is one result per N+1 cycles.
- With DIGIT = WIDTH: a single RUN cycle, latency 2.
- done and busy are never both 1.

## Configuration
- FSUB_SAT_EN defined: unsigned saturation is enabled. When the final borrow = 1, d is loaded with 0 instead of the wrapped difference. bo still reports 1.
- FSUB_SAT_EN undefined: d is the modulo-2^WIDTH wrapped difference.
- Timing and handshake are identical in both builds.

## Test plan
- Default params: a = 0x1234, b = 0x0034, start pulse. Required: busy high 16 cycles, then done one cycle with d = 0x1200, bo = 0.
- a = 0x0000, b = 0x0001. Required: d = 0xFFFF, bo = 1. With FSUB_SAT_EN: d = 0x0000, bo = 1.
- a = 0xFFFF, b = 0xFFFF, then a = 0x8000, b = 0x7FFF. Required: d = 0x0000, bo = 0, then d = 0x0001, bo = 0.
- Accept a = 0x00F0, b = 0x000F. Pulse start with a = 0x0001, b = 0x0002 on cycle 5 of RUN. Required: second start ignored, result d = 0x00E1, bo = 0 at cycle 17.
- Assert rst on cycle 8 of RUN. Required: next cycle busy = 0, done = 0, d = 0, bo = 0. No done pulse is issued afterward.
- Hold start = 1 continuously with a = 0x0005, b = 0x0003. Required: done every 17 cycles, d = 0x0002 each time. A start during DONE is accepted with no idle gap. Repeat with DIGIT = 4: done every 5 cycles.
